// File: rtl/msg_deframer_if.sv
// Stream bundle (data, valid, last, ready) shared by the framed input
// and the payload-only output of msg_deframer.
interface msg_deframer_if;
  logic [31:0] TDATA;
  logic        TVALID;
  logic        TLAST;
  logic        TREADY;

  modport master (output TDATA, TVALID, TLAST, input TREADY);
  modport slave  (input TDATA, TVALID, TLAST, output TREADY);
endinterface

// File: rtl/msg_deframer.sv
// Strips and checks the header word of each framed message and forwards the payload.
// Optional feature: define MSG_DEFRAMER_BROADCAST_EN so that RX_UID 0xFF matches any my_uid.
module msg_deframer #(
  parameter int unsigned MAX_LEN_BYTES = 4096
) (
  input  logic           clk_200MHz,
  input  logic           peripheral_reset,
  input  logic [7:0]     my_uid,
  msg_deframer_if.slave  s_axis,
  msg_deframer_if.master m_axis,
  output logic           hdr_valid,
  output logic [7:0]     hdr_tx_uid,
  output logic [15:0]    hdr_len,
  output logic           err_uid,
  output logic           err_len,
  output logic [15:0]    msg_count
);

  typedef enum logic [1:0] {HEADER, PAYLOAD, DROP} state_e;

  state_e      state_q;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] m_data_q;
  logic        m_valid_q, m_last_q;
  logic        hdr_valid_q, err_uid_q, err_len_q;
  logic [7:0]  hdr_tx_uid_q;
  logic [15:0] hdr_len_q, msg_count_q;

  logic        s_ready, s_fire;
  logic [7:0]  rx_uid, tx_uid;
  logic [15:0] len;
  logic        uid_ok, len_ok;

  assign rx_uid = s_axis.TDATA[31:24];
  assign tx_uid = s_axis.TDATA[23:16];
  assign len    = s_axis.TDATA[15:0];

`ifdef MSG_DEFRAMER_BROADCAST_EN
  assign uid_ok = (rx_uid == my_uid) || (rx_uid == 8'hFF);
`else
  assign uid_ok = (rx_uid == my_uid);
`endif

  assign len_ok = (len != 16'd0) && (len[1:0] == 2'b00) && (32'(len) <= MAX_LEN_BYTES);

  // Ready is held low for the whole time reset is asserted, and rises as soon as it drops.
  always_comb begin
    // NOTE: default assignment first so no path through the case can infer a latch.
    s_ready = 1'b0;
    if (!peripheral_reset) begin
      unique case (state_q)
        HEADER, DROP: s_ready = 1'b1;
        PAYLOAD:      s_ready = !m_valid_q || m_axis.TREADY;
        default:      s_ready = 1'b0;
      endcase
    end
  end

  assign s_fire = s_axis.TVALID && s_ready;
  assign cnt_d  = cnt_q - 16'd1;

  // NOTE: non-blocking assignments only, so every branch sees pre-edge register values.
  always_ff @(posedge clk_200MHz) begin
    if (peripheral_reset) begin
      state_q      <= HEADER;
      cnt_q        <= '0;
      m_data_q     <= '0;
      m_valid_q    <= 1'b0;
      m_last_q     <= 1'b0;
      hdr_valid_q  <= 1'b0;
      hdr_tx_uid_q <= '0;
      hdr_len_q    <= '0;
      err_uid_q    <= 1'b0;
      err_len_q    <= 1'b0;
      msg_count_q  <= '0;
    end else begin
      hdr_valid_q <= 1'b0;
      err_uid_q   <= 1'b0;
      err_len_q   <= 1'b0;

      if (m_valid_q && m_axis.TREADY) m_valid_q <= 1'b0;

      if (s_fire) begin
        unique case (state_q)
          HEADER: begin
            // A single-beat frame is already fully consumed, so stay put.
            if (s_axis.TLAST) begin
              err_len_q <= 1'b1;
            end else if (!uid_ok) begin
              err_uid_q <= 1'b1;
              state_q   <= DROP;
            end else if (!len_ok) begin
              err_len_q <= 1'b1;
              state_q   <= DROP;
            end else begin
              hdr_valid_q  <= 1'b1;
              hdr_tx_uid_q <= tx_uid;
              hdr_len_q    <= len;
              cnt_q        <= {2'b00, len[15:2]};
              state_q      <= PAYLOAD;
            end
          end
          PAYLOAD: begin
            m_valid_q <= 1'b1;
            m_data_q  <= s_axis.TDATA;
            m_last_q  <= (cnt_q == 16'd1) || s_axis.TLAST;
            cnt_q     <= cnt_d;
            if (cnt_q == 16'd1) begin
              if (s_axis.TLAST) begin
                msg_count_q <= msg_count_q + 16'd1;
                state_q     <= HEADER;
              end else begin
                err_len_q <= 1'b1;
                state_q   <= DROP;
              end
            end else if (s_axis.TLAST) begin
              err_len_q <= 1'b1;
              state_q   <= HEADER;
            end
          end
          DROP: begin
            if (s_axis.TLAST) state_q <= HEADER;
          end
          default: state_q <= HEADER;
        endcase
      end
    end
  end

  assign s_axis.TREADY = s_ready;
  assign m_axis.TDATA  = m_data_q;
  assign m_axis.TVALID = m_valid_q;
  assign m_axis.TLAST  = m_last_q;
  assign hdr_valid     = hdr_valid_q;
  assign hdr_tx_uid    = hdr_tx_uid_q;
  assign hdr_len       = hdr_len_q;
  assign err_uid       = err_uid_q;
  assign err_len       = err_len_q;
  assign msg_count     = msg_count_q;

endmodule

// File: tb/tb_msg_deframer.sv
// Self-checking bench for msg_deframer: a frame-level model predicts output words,
// header fields, pulse counts and msg_count; a negedge monitor compares every transfer.
module tb_msg_deframer;
  localparam int MAXB = 4096;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  my_uid;
  logic        hdr_valid, err_uid, err_len;
  logic [7:0]  hdr_tx_uid;
  logic [15:0] hdr_len, msg_count;

  msg_deframer_if s_if ();
  msg_deframer_if m_if ();

  msg_deframer #(.MAX_LEN_BYTES(MAXB)) dut (
    .clk_200MHz      (clk),
    .peripheral_reset(rst),
    .my_uid          (my_uid),
    .s_axis          (s_if),
    .m_axis          (m_if),
    .hdr_valid       (hdr_valid),
    .hdr_tx_uid      (hdr_tx_uid),
    .hdr_len         (hdr_len),
    .err_uid         (err_uid),
    .err_len         (err_len),
    .msg_count       (msg_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- model state ----------------
  logic [31:0] pay [0:1031];
  logic [32:0] exp_q [$];
  int          exp_hdr = 0, exp_eu = 0, exp_el = 0;
  logic [15:0] exp_cnt = '0;
  logic [7:0]  exp_tx  = '0;
  logic [15:0] exp_len = '0;

  int obs_hdr = 0, obs_eu = 0, obs_el = 0, obs_out = 0;
  int stalls = 0;
  bit ignore_out = 1'b0;
  int rmode = 0;

  // Frame = header + m payload beats, TLAST on the final beat of the frame.
  task automatic model_frame(input logic [31:0] hdr, input int m);
    int n, k, l;
    bit uid_ok;
    uid_ok = (hdr[31:24] == my_uid);
`ifdef MSG_DEFRAMER_BROADCAST_EN
    if (hdr[31:24] == 8'hFF) uid_ok = 1'b1;
`endif
    l = int'(hdr[15:0]);
    if (m == 0) exp_el++;
    else if (!uid_ok) exp_eu++;
    else if (l == 0 || (l % 4) != 0 || l > MAXB) exp_el++;
    else begin
      exp_hdr++;
      exp_tx  = hdr[23:16];
      exp_len = hdr[15:0];
      n = l / 4;
      k = (m < n) ? m : n;
      for (int i = 0; i < k; i++) exp_q.push_back({(i == k - 1), pay[i]});
      if (m == n) exp_cnt = exp_cnt + 16'd1;
      else exp_el++;
    end
  endtask

  // ---------------- drivers ----------------
  task automatic beat(input logic [31:0] d, input logic l);
    int w;
    bit r;
    w = 0;
    s_if.TDATA  = d;
    s_if.TLAST  = l;
    s_if.TVALID = 1'b1;
    forever begin
      @(negedge clk);
      r = s_if.TREADY;
      @(posedge clk);
      if (r) break;
      stalls++;
      w++;
      if (w > 100) begin
        n_checks++;
        n_errors++;
        $display("FAIL beat_timeout: TREADY low for %0d cycles, expected a transfer", w);
        break;
      end
    end
    #1;
    s_if.TVALID = 1'b0;
    s_if.TLAST  = 1'b0;
  endtask

  task automatic send_frame(input logic [31:0] hdr, input int m);
    model_frame(hdr, m);
    beat(hdr, (m == 0));
    for (int i = 0; i < m; i++) beat(pay[i], (i == m - 1));
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 5000) begin
      @(posedge clk);
      t++;
    end
    repeat (4) @(posedge clk);
    #1;
    check("drain_remaining_words", exp_q.size(), 0);
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_hdr_valid_pulses"}, obs_hdr, exp_hdr);
    check({tag, "_err_uid_pulses"}, obs_eu, exp_eu);
    check({tag, "_err_len_pulses"}, obs_el, exp_el);
    check({tag, "_msg_count"}, msg_count, exp_cnt);
    check({tag, "_hdr_tx_uid"}, hdr_tx_uid, exp_tx);
    check({tag, "_hdr_len"}, hdr_len, exp_len);
  endtask

  // Downstream ready: always high, or 1 cycle on / 2 cycles off.
  initial begin
    int ph;
    ph = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rmode == 0) m_if.TREADY = 1'b1;
      else begin
        m_if.TREADY = (ph == 0);
        ph = (ph + 1) % 3;
      end
    end
  end

  // ---------------- monitor / compare ----------------
  logic [32:0] e;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_data;
  logic        prev_last;

  always @(negedge clk) begin
    if (!rst) begin
      if (hdr_valid) obs_hdr++;
      if (err_uid) obs_eu++;
      if (err_len) obs_el++;
      if (prev_stall) begin
        check("hold_valid", m_if.TVALID, 1'b1);
        check("hold_data", m_if.TDATA, prev_data);
        check("hold_last", m_if.TLAST, prev_last);
      end
      if (m_if.TVALID && m_if.TREADY && !ignore_out) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL out_unexpected: got word 0x%0h last=%0b, expected no output", m_if.TDATA, m_if.TLAST);
        end else begin
          e = exp_q.pop_front();
          check("out_data", m_if.TDATA, e[31:0]);
          check("out_last", m_if.TLAST, e[32]);
          obs_out++;
        end
      end
    end
    prev_stall = !rst && m_if.TVALID && !m_if.TREADY;
    prev_data  = m_if.TDATA;
    prev_last  = m_if.TLAST;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  int base_out, base_el, base_eu;

  initial begin
    rst = 1'b1;
    my_uid = 8'h01;
    s_if.TDATA = '0;
    s_if.TVALID = 1'b0;
    s_if.TLAST = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_s_tready", s_if.TREADY, 1'b0);
    check("rst_m_tvalid", m_if.TVALID, 1'b0);
    check("rst_m_tlast", m_if.TLAST, 1'b0);
    check("rst_m_tdata", m_if.TDATA, 32'h0);
    check("rst_hdr_valid", hdr_valid, 1'b0);
    check("rst_hdr_tx_uid", hdr_tx_uid, 8'h0);
    check("rst_hdr_len", hdr_len, 16'h0);
    check("rst_err_uid", err_uid, 1'b0);
    check("rst_err_len", err_len, 1'b0);
    check("rst_msg_count", msg_count, 16'h0);
    rst = 1'b0;
    #1;
    check("tready_after_release", s_if.TREADY, 1'b1);

    // Nominal 216-word message of ones.
    for (int i = 0; i < 216; i++) pay[i] = 32'h1;
    base_out = obs_out;
    stalls = 0;
    send_frame(32'h01000360, 216);
    drain();
    check("nominal_out_words", obs_out - base_out, 216);
    check("nominal_msg_count_lit", msg_count, 16'd1);
    check("nominal_hdr_len_lit", hdr_len, 16'h0360);
    check("nominal_hdr_tx_uid_lit", hdr_tx_uid, 8'h00);
    check("nominal_err_pulses_lit", obs_eu + obs_el, 0);
    check("nominal_no_stall", stalls, 0);
    check_counts("nominal");

    // Varied data pattern through the output register.
    for (int i = 0; i < 8; i++) pay[i] = 32'hA5000000 + 32'(i * 32'h01010101);
    send_frame(32'h01AB0020, 8);
    drain();
    check_counts("varied");

    // UID mismatch: whole message dropped without back-pressure, then recovery.
    my_uid = 8'h02;
    for (int i = 0; i < 216; i++) pay[i] = 32'h1;
    base_out = obs_out;
    base_eu = obs_eu;
    stalls = 0;
    send_frame(32'h01000360, 216);
    drain();
    check("uid_drop_out_words", obs_out - base_out, 0);
    check("uid_drop_err_uid_lit", obs_eu - base_eu, 1);
    check("uid_drop_no_stall", stalls, 0);
    for (int i = 0; i < 2; i++) pay[i] = 32'hC0DE0000 + 32'(i);
    send_frame(32'h02070008, 2);
    drain();
    check_counts("uid_recover");
    my_uid = 8'h01;

    // Early TLAST, then overrun.
    for (int i = 0; i < 4; i++) pay[i] = 32'h11110000 + 32'(i);
    base_out = obs_out;
    base_el = obs_el;
    send_frame(32'h01000010, 2);
    drain();
    check("early_last_out_words", obs_out - base_out, 2);
    check("early_last_err_len_lit", obs_el - base_el, 1);
    check("early_last_msg_count_lit", msg_count, 16'd3);
    base_out = obs_out;
    send_frame(32'h01000008, 4);
    drain();
    check("overrun_out_words", obs_out - base_out, 2);
    check("overrun_msg_count_lit", msg_count, 16'd3);
    check_counts("len_mismatch");

    // Malformed headers, then a good single-word message.
    pay[0] = 32'h0BAD0BAD;
    pay[1] = 32'h0BAD0BAE;
    send_frame(32'h01000006, 1);
    send_frame(32'h01000000, 1);
    send_frame(32'h01001004, 2);
    send_frame(32'h02000006, 1);
    send_frame(32'h01000004, 0);
    pay[0] = 32'h600DF00D;
    send_frame(32'h01330004, 1);
    drain();
    check_counts("bad_headers");

    // Largest legal length.
    for (int i = 0; i < 1024; i++) pay[i] = 32'(i) ^ 32'h5A5A0000;
    base_out = obs_out;
    send_frame(32'h01441000, 1024);
    drain();
    check("max_len_out_words", obs_out - base_out, 1024);
    check_counts("max_len");

    // Downstream throttled 1 on / 2 off.
    rmode = 1;
    for (int i = 0; i < 216; i++) pay[i] = 32'h1;
    base_out = obs_out;
    send_frame(32'h01000360, 216);
    drain();
    check("throttle_out_words", obs_out - base_out, 216);
    for (int i = 0; i < 20; i++) pay[i] = 32'hBEEF0000 + 32'(i * 7);
    send_frame(32'h01550050, 20);
    drain();
    check_counts("throttle");
    rmode = 0;
    repeat (3) @(posedge clk);
    #1;

    // Back-to-back messages under continuous valid/ready.
    stalls = 0;
    for (int i = 0; i < 3; i++) pay[i] = 32'h77000000 + 32'(i);
    send_frame(32'h0166000C, 3);
    send_frame(32'h0167000C, 3);
    drain();
    check("back_to_back_no_stall", stalls, 0);
    check_counts("back_to_back");

    // Reset in the middle of a message, then resend.
    ignore_out = 1'b1;
    exp_hdr++;
    for (int i = 0; i < 216; i++) pay[i] = 32'h1;
    beat(32'h01000360, 1'b0);
    for (int i = 0; i < 100; i++) beat(pay[i], 1'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("midrst_s_tready", s_if.TREADY, 1'b0);
    check("midrst_m_tvalid", m_if.TVALID, 1'b0);
    check("midrst_msg_count", msg_count, 16'd0);
    exp_q.delete();
    exp_cnt = '0;
    exp_tx = '0;
    exp_len = '0;
    rst = 1'b0;
    ignore_out = 1'b0;
    #1;
    check("midrst_tready_after_release", s_if.TREADY, 1'b1);
    base_out = obs_out;
    send_frame(32'h01000360, 216);
    drain();
    check("midrst_out_words", obs_out - base_out, 216);
    check("midrst_msg_count_lit", msg_count, 16'd1);
    check_counts("midrst");

    // Broadcast UID.
    pay[0] = 32'hFACEB00C;
    base_out = obs_out;
    send_frame(32'hFF000004, 1);
    drain();
`ifdef MSG_DEFRAMER_BROADCAST_EN
    check("broadcast_out_words", obs_out - base_out, 1);
`else
    check("broadcast_out_words", obs_out - base_out, 0);
`endif
    check_counts("broadcast");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
